sar_search: RTL

- Successive-approximation search engine that drives probe words into an external WIDTH-bit magnitude comparator and consumes its one-hot lt/eq/gt result.
- Acts as the initiator in front of the comparator. It converges bit by bit, MSB first, to the largest probe P for which f(P) <= reference.
- With an identity comparator (probe vs constant), result equals the reference.
- Sits beside comparator instances in benchmark and arithmetic datapaths, e.g. integer square root or threshold search.

---
 rtl/sar_search.sv | 104 ++++++++++
 1 files changed

// File: rtl/sar_search.sv
// Successive-approximation search: drives probe words into an external comparator and converges MSB-first
// to the largest probe whose comparator result is not greater than the reference.
module sar_search #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err,
    output logic [WIDTH-1:0] probe,
    output logic             probe_valid,
    input  logic             cmp_valid,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] cand;
    logic             onehot;

    always_comb begin
        bit_mask = '0;
        bit_mask[idx] = 1'b1;
        cand = cmp_gt ? (probe & ~bit_mask) : probe;
        onehot = ({cmp_lt, cmp_eq, cmp_gt} == 3'b100) ||
                 ({cmp_lt, cmp_eq, cmp_gt} == 3'b010) ||
                 ({cmp_lt, cmp_eq, cmp_gt} == 3'b001);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            probe       <= '0;
            result      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            exact       <= 1'b0;
            err         <= 1'b0;
            probe_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        probe       <= '0;
                        probe[WIDTH-1] <= 1'b1;
                        idx         <= IW'(WIDTH - 1);
                        exact       <= 1'b0;
                        err         <= 1'b0;
                        busy        <= 1'b1;
                        probe_valid <= 1'b1;
                        state       <= PROBE;
                    end
                end
                PROBE: begin
                    if (cmp_valid) begin
                        if (!onehot || cmp_eq || idx == '0) begin
                            // Every terminating outcome lands here; the result depends on which one.
                            if (!onehot) begin
                                err    <= 1'b1;
                                result <= probe & ~bit_mask;
                            end else if (cmp_eq) begin
                                exact  <= 1'b1;
                                result <= probe;
                            end else begin
                                result <= cand;
                            end
                            busy        <= 1'b0;
                            probe_valid <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            probe <= cand | (bit_mask >> 1);
                            idx   <= idx - IW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    probe_valid <= 1'b0;
                    done        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
